// File: rtl/send_ascii_top.sv
// send_ascii_top: push-button driven 8N1 UART transmitter for board bring-up.
// Each debounced press of btn sends the next ASCII character ('0'..'z', wrapping).
// Optional macro SEND_CRLF_EN: each character frame is followed back-to-back
// by CR (0x0D) and LF (0x0A) frames.
`timescale 1ns/1ps
module send_ascii_top #(
  parameter int          CLK_FREQ        = 100_000_000,
  parameter int          BAUD            = 9600,
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [7:0]  FIRST_CHAR      = 8'h30,
  parameter logic [7:0]  LAST_CHAR       = 8'h7A
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic tx
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int BW         = $clog2(BIT_CYCLES + 1);
  localparam int DW         = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [1:0]      btn_sync;
  logic            db_lvl, db_d, press;
  logic [DW-1:0]   db_cnt;
  logic [7:0]      chr, chr_n, shreg, shreg_n;
  logic [BW-1:0]   baud_cnt, baud_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic            tx_n, bit_end;
`ifdef SEND_CRLF_EN
  // 0: character frame, 1: CR frame, 2: LF frame
  logic [1:0]      fsel, fsel_n;
`endif

  // Synchronise btn, debounce it, and remember last level for edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_sync <= '0;
      db_lvl   <= 1'b0;
      db_d     <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_sync <= {btn_sync[0], btn};
      db_d     <= db_lvl;
      if (btn_sync[1] == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_lvl <= btn_sync[1];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  // Press pulse only on the debounced rising edge; release is ignored
  assign press   = db_lvl & ~db_d;
  assign bit_end = (baud_cnt == BW'(BIT_CYCLES - 1));

  // Transmitter state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next state, datapath next values, and the next tx level (registered below)
  always_comb begin
    state_n   = state;
    baud_n    = baud_cnt + BW'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    chr_n     = chr;
    tx_n      = 1'b1;
`ifdef SEND_CRLF_EN
    fsel_n    = fsel;
`endif
    case (state)
      IDLE: begin
        // Baud counter held at 0 so every frame starts from a clean phase
        baud_n = '0;
        if (press) begin
          state_n = START;
          shreg_n = chr;
          chr_n   = (chr == LAST_CHAR) ? FIRST_CHAR : chr + 8'd1;
`ifdef SEND_CRLF_EN
          fsel_n  = 2'd0;
`endif
        end
      end
      START: if (bit_end) begin
        state_n   = DATA;
        baud_n    = '0;
        bit_idx_n = '0;
      end
      DATA: if (bit_end) begin
        baud_n    = '0;
        bit_idx_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_n = STOP;
      end
      STOP: if (bit_end) begin
        baud_n  = '0;
        state_n = IDLE;
`ifdef SEND_CRLF_EN
        if (fsel != 2'd2) begin
          state_n = START;
          fsel_n  = fsel + 2'd1;
          shreg_n = (fsel == 2'd0) ? 8'h0D : 8'h0A;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[bit_idx_n];
      default: tx_n = 1'b1;
    endcase
  end

  // Datapath registers; tx comes straight from a flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx       <= 1'b1;
      chr      <= FIRST_CHAR;
      shreg    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
`ifdef SEND_CRLF_EN
      fsel     <= '0;
`endif
    end else begin
      tx       <= tx_n;
      chr      <= chr_n;
      shreg    <= shreg_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_idx_n;
`ifdef SEND_CRLF_EN
      fsel     <= fsel_n;
`endif
    end
  end

endmodule

// File: tb/tb_send_ascii_top.sv
// Testbench for send_ascii_top: randomized presses, tx decoded into frames and
// compared with an ideal 8N1 waveform built from a character-sequence model.
`timescale 1ns/1ps
module tb_send_ascii_top;
  localparam int CF = 1000, BD = 100, DEB = 4, BC = CF / BD;

  logic clk = 1'b0, reset = 1'b0, btn = 1'b0;
  logic tx;
  int   cyc = 0, checks = 0, errors = 0, t_rise = 0, nacc = 0;
  logic [7:0] mchar = 8'h30, got, exp_c;

  send_ascii_top #(.CLK_FREQ(CF), .BAUD(BD), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .btn(btn), .tx(tx));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  // Model: next character the design should send for an accepted press
  function automatic logic [7:0] next_char();
    logic [7:0] c = mchar;
    mchar = (mchar == 8'h7A) ? 8'h30 : mchar + 8'd1;
    return c;
  endfunction

  // Optional 2-cycle bounce toggles, clean rise held 'hold' cycles, then release
  task automatic press(input int hold, input int bounce);
    @(posedge clk); #1;
    for (int i = 0; i < bounce; i++) begin
      btn = (i % 2 == 0);
      repeat (2) @(posedge clk);
      #1;
    end
    btn = 1'b1;
    t_rise = cyc;
    repeat (hold) @(posedge clk);
    #1 btn = 1'b0;
    repeat (DEB + 4) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    int z = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) z++;
    end
    chk(tag, z, 0);
  endtask

  // Capture one frame cycle by cycle and compare with the ideal waveform
  task automatic recv(input logic [7:0] ch, input bit first, output logic [7:0] g);
    int n = 0;
    logic [10*BC-1:0] w, e;
    g = '0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      chk("start_timeout", tx, 0);
      return;
    end
    if (first) chk("latency_7_9", (cyc - t_rise >= 7) && (cyc - t_rise <= 9), 1);
    else       chk("back_to_back", n, 0);
    for (int i = 0; i < 10*BC; i++) begin
      if (i > 0) @(negedge clk);
      w[i] = tx;
      if (i < BC)         e[i] = 1'b0;
      else if (i >= 9*BC) e[i] = 1'b1;
      else                e[i] = ch[i/BC - 1];
    end
    for (int k = 0; k < 8; k++) g[k] = w[(k+1)*BC + BC/2];
    chk("frame_wave", w, e);
    chk("frame_char", g, ch);
  endtask

  task automatic recv_all(input logic [7:0] ch, output logic [7:0] g);
`ifdef SEND_CRLF_EN
    logic [7:0] g2;
`endif
    recv(ch, 1'b1, g);
`ifdef SEND_CRLF_EN
    recv(8'h0D, 1'b0, g2);
    recv(8'h0A, 1'b0, g2);
`endif
  endtask

  task automatic wait_low();
    int n = 0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) chk("wait_low_timeout", tx, 0);
  endtask

  initial begin
    // reset
    repeat (3) begin
      @(negedge clk);
      chk("reset_tx", tx, 1);
    end
    @(posedge clk); #1 reset = 1'b1;
    idle(200, "idle_after_reset");

    // single clean press
    exp_c = next_char();
    fork press(20, 0); recv_all(exp_c, got); join
    chk("first_is_30", got, 8'h30);
    nacc = 1;

    // bounce then hold; release must not send anything
    exp_c = next_char();
    fork press(20, 10); recv_all(exp_c, got); join
    idle(150, "no_frame_on_release");
    nacc = 2;

    // randomized presses up to the wrap point
    while (nacc < 76) begin
      int h = $urandom_range(6, 25);
      int b = 2 * $urandom_range(0, 4);
      exp_c = next_char();
      fork press(h, b); recv_all(exp_c, got); join
      nacc++;
      if (nacc == 75) chk("char75_is_7A", got, 8'h7A);
      if (nacc == 76) chk("char76_wraps", got, 8'h30);
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end

    // press during a frame is dropped
    exp_c = next_char();
    fork
      begin press(20, 0); press(15, 0); end
      recv_all(exp_c, got);
    join
    idle(120, "busy_press_dropped");
    exp_c = next_char();
    fork press(20, 0); recv_all(exp_c, got); join

    // reset in the middle of DATA aborts the frame
    fork
      press(20, 0);
      begin
        wait_low();
        repeat (30) @(negedge clk);
        reset = 1'b0;
        #1 chk("reset_abort_tx", tx, 1);
      end
    join
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(150, "no_resume_after_reset");
    mchar = 8'h30;
    exp_c = next_char();
    fork press(20, 0); recv_all(exp_c, got); join
    chk("char_after_reset", got, 8'h30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
